// File: rtl/mips_div_iter.sv
// mips_div_iter: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Returns {remainder, quotient} as {hi, lo}. Operands are taken once at accept;
// one quotient bit is produced per cycle, and a one-cycle ready_o pulse follows.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor short-circuits through
// a one-cycle DIVZERO state and returns 64'b0 instead of iterating.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for start_i with annul_i low
//   BUSY    | shift/subtract iterations, counter 0..DATA_W-1
//   DONE    | ready_o pulse, result_o carries sign-corrected hi/lo
//   DIVZERO | zero-divisor bypass, one cycle (DIV_ZERO_FAST_EN only)
module mips_div_iter #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
`ifdef DIV_ZERO_FAST_EN
    , S_DIVZERO
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W:0]     work_q, work_d;     // {rem[DATA_W:0], quot[DATA_W-1:0]}
  logic [DATA_W-1:0]     dvsr_q, dvsr_d;
  logic                  quo_neg_q, quo_neg_d;
  logic                  rem_neg_q, rem_neg_d;
`ifdef DIV_ZERO_FAST_EN
  logic                  zero_q, zero_d;
`endif

  logic [DATA_W-1:0]     a_abs, b_abs;
  logic [DATA_W+1:0]     rem_top;
  logic [DATA_W+1:0]     diff;
  logic [DATA_W-1:0]     rem_mag, quo_mag;

  assign a_abs   = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign b_abs   = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  // Partial remainder after the left shift; the extra top bit is always zero,
  // so diff's MSB is a clean borrow flag.
  assign rem_top = work_q[2*DATA_W:DATA_W-1];
  assign diff    = rem_top - {2'b00, dvsr_q};
  assign rem_mag = work_q[2*DATA_W-1:DATA_W];
  assign quo_mag = work_q[DATA_W-1:0];

  // Next-state, datapath updates and outputs; everything holds by default.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    dvsr_d    = dvsr_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
`ifdef DIV_ZERO_FAST_EN
    zero_d    = zero_q;
`endif
    ready_o   = 1'b0;
    result_o  = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          dvsr_d    = b_abs;
          quo_neg_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          rem_neg_d = signed_div_i & opdata1_i[DATA_W-1];
          work_d    = {{(DATA_W+1){1'b0}}, a_abs};
          cnt_d     = '0;
          state_d   = S_BUSY;
`ifdef DIV_ZERO_FAST_EN
          zero_d    = (opdata2_i == '0);
          if (opdata2_i == '0) state_d = S_DIVZERO;
`endif
        end
      end

      S_BUSY: begin
        if (annul_i || !start_i) begin
          state_d = S_IDLE;
        end else begin
          if (!diff[DATA_W+1])
            work_d = {diff[DATA_W:0], work_q[DATA_W-2:0], 1'b1};
          else
            work_d = {work_q[2*DATA_W-1:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W-1)) state_d = S_DONE;
        end
      end

`ifdef DIV_ZERO_FAST_EN
      S_DIVZERO: begin
        if (annul_i || !start_i) state_d = S_IDLE;
        else                     state_d = S_DONE;
      end
`endif

      S_DONE: begin
        ready_o  = 1'b1;
        result_o = {rem_neg_q ? -rem_mag : rem_mag,
                    quo_neg_q ? -quo_mag : quo_mag};
`ifdef DIV_ZERO_FAST_EN
        if (zero_q) result_o = '0;
`endif
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      dvsr_q    <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
      zero_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      dvsr_q    <= dvsr_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
`ifdef DIV_ZERO_FAST_EN
      zero_q    <= zero_d;
`endif
    end
  end

endmodule

// File: tb/tb_mips_div_iter.sv
// Scoreboard bench for mips_div_iter: expected {hi, lo} and latency are queued
// at issue and compared when ready_o pulses.
module tb_mips_div_iter;

  logic        clk;
  logic        rst;
  logic        sg;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result_o;
  logic        ready_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_rdy = 0;

  typedef struct {
    logic [63:0] res;
    int          acc;
    int          lat;
  } sb_t;
  sb_t sb[$];

  mips_div_iter #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (sg),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] expect_res(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] aa, bb, q, r;
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'd0) return 64'd0;
`endif
    aa = (s && a[31]) ? -a : a;
    bb = (s && b[31]) ? -b : b;
    q  = (bb == 32'd0) ? 32'hFFFF_FFFF : aa / bb;
    r  = (bb == 32'd0) ? aa : aa % bb;
    if (s && (a[31] ^ b[31])) q = -q;
    if (s && a[31])           r = -r;
    return {r, q};
  endfunction

  function automatic int expect_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'd0) return 1;
`endif
    return 32;
  endfunction

  // Result and latency check on every completion pulse.
  always @(negedge clk) begin
    if (ready_o) begin
      if (sb.size() == 0) begin
        chk("spurious_ready", 64'(ready_o), 64'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("result", result_o, e.res);
        chk("latency", 64'(cyc - e.acc), 64'(e.lat));
        last_rdy = cyc;
      end
    end
  end

  // Called just after a posedge with the DUT in IDLE; accept is the next edge.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] e, input int lat);
    sb_t x;
    sg    = s;
    op1   = a;
    op2   = b;
    annul = 1'b0;
    start = 1'b1;
    x.res = e;
    x.acc = cyc + 1;
    x.lat = lat;
    sb.push_back(x);
  endtask

  task automatic wait_ready();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o) begin
        got = 1'b1;
        break;
      end
      chk("result_zero_busy", result_o, 64'd0);
      if (i > 0) begin
        op1 = $urandom;
        op2 = $urandom;
        sg  = 1'($urandom_range(0, 1));
      end
    end
    if (!got) begin
      chk("ready_timeout", 64'(ready_o), 64'd1);
      while (sb.size() > 0) void'(sb.pop_front());
    end
  endtask

  task automatic finish_op();
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("ready_single_cycle", 64'(ready_o), 64'd0);
  endtask

  task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] e, input int lat);
    @(posedge clk); #1;
    issue(s, a, b, e, lat);
    wait_ready();
    finish_op();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        s;
    logic [31:0] a, b;
    int          t1, t2;

    rst = 1'b1; start = 1'b0; annul = 1'b0; sg = 1'b0; op1 = '0; op2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed values
    run(1'b0, 32'd100,        32'd7,        {32'h0000_0002, 32'h0000_000E}, 32);
    run(1'b1, 32'hFFFF_FFF9,  32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 32);
    run(1'b1, 32'd7,          32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 32);
    run(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 32);
    run(1'b0, 32'hFFFF_FFFF,  32'd1,        {32'h0000_0000, 32'hFFFF_FFFF}, 32);
`ifdef DIV_ZERO_FAST_EN
    run(1'b0, 32'd5,          32'd0,        64'd0, 1);
    run(1'b1, 32'hFFFF_FFF9,  32'd0,        64'd0, 1);
`else
    run(1'b0, 32'd5,          32'd0,        {32'h0000_0005, 32'hFFFF_FFFF}, 32);
    run(1'b1, 32'hFFFF_FFF9,  32'd0,        {32'hFFFF_FFF9, 32'h0000_0001}, 32);
`endif

    // Random operands
    for (int k = 0; k < 8; k++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      run(s, a, b, expect_res(s, a, b), expect_lat(b));
    end

    // Annul at BUSY cycle 10, start kept high: the next IDLE cycle accepts anew
    @(posedge clk); #1;
    issue(1'b0, 32'd1000, 32'd3, expect_res(1'b0, 32'd1000, 32'd3), 32);
    repeat (10) @(posedge clk);
    #1 annul = 1'b1;
    void'(sb.pop_back());
    @(posedge clk); #1;
    issue(1'b1, 32'hFFFF_FF00, 32'd16, expect_res(1'b1, 32'hFFFF_FF00, 32'd16), 32);
    wait_ready();
    finish_op();

    // start_i dropped at BUSY cycle 10, new division two cycles later
    @(posedge clk); #1;
    issue(1'b0, 32'd12345, 32'd67, expect_res(1'b0, 32'd12345, 32'd67), 32);
    repeat (10) @(posedge clk);
    #1 start = 1'b0;
    void'(sb.pop_back());
    repeat (3) begin
      @(negedge clk);
      chk("drop_ready", 64'(ready_o), 64'd0);
      chk("drop_result", result_o, 64'd0);
    end
    @(posedge clk); #1;
    issue(1'b1, 32'd99, 32'hFFFF_FFF6, expect_res(1'b1, 32'd99, 32'hFFFF_FFF6), 32);
    wait_ready();
    finish_op();

    // Back-to-back DIVU
    @(posedge clk); #1;
    issue(1'b0, 32'd1000000, 32'd37, expect_res(1'b0, 32'd1000000, 32'd37), 32);
    wait_ready();
    @(posedge clk); #1;
    t1 = last_rdy;
    issue(1'b0, 32'd999, 32'd1000, expect_res(1'b0, 32'd999, 32'd1000), 32);
    wait_ready();
    @(posedge clk); #1;
    t2 = last_rdy;
    chk("b2b_spacing", 64'(t2 - t1), 64'd34);
    start = 1'b0;
    @(negedge clk);
    chk("b2b_ready_low", 64'(ready_o), 64'd0);

    // Reset mid-BUSY with start held: the division after reset must start fresh
    @(posedge clk); #1;
    issue(1'b1, 32'hFFFF_FF9C, 32'd7, expect_res(1'b1, 32'hFFFF_FF9C, 32'd7), 32);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    void'(sb.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_result", result_o, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    issue(1'b0, 32'd77, 32'd5, expect_res(1'b0, 32'd77, 32'd5), 32);
    wait_ready();
    finish_op();

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
